// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive front end.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_EOP_WAIT,
        ST_ERR_WAIT
    } rx_asm_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    // Line states as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // NRZI: no change in level decodes as 1, a change decodes as 0
    function automatic logic nrzi_bit(input logic level, input logic prev_level);
        return level == prev_level;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-time recovery: free-running bit counter resynchronised on every d_plus
// edge, with a mid-bit sample strobe and a falling-edge detect for packet start.
module rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run,
    input  logic d_plus,
    output logic sample,
    output logic fall
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] r_cnt;
    logic          r_dp_prev;
    logic          w_edge;

    assign w_edge = d_plus ^ r_dp_prev;
    assign fall   = r_dp_prev & ~d_plus;
    assign sample = run && (r_cnt == MID);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt     <= '0;
            r_dp_prev <= 1'b1;
        end else begin
            r_dp_prev <= d_plus;
            if (!run || w_edge)
                r_cnt <= '0;
            else if (r_cnt == LAST)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rx_byte_assembler.sv
// USB full-speed RX front end: NRZI decode, bit unstuffing and LSB-first byte
// assembly, with EOP, stuffing and alignment error reporting.
module rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    input  logic       enable,
    output logic [7:0] Packet_Data,
    output logic       byte_complete,
    output logic       eop,
    output logic       stuff_error,
    output logic       align_error,
    output logic       receiving
);

    rx_asm_state_t r_state, w_state_nxt;

    logic       r_prev_level, w_prev_nxt;
    logic [2:0] r_ones,       w_ones_nxt;
    logic [2:0] r_bitcnt,     w_bitcnt_nxt;
    logic [7:0] r_shift,      w_shift_nxt;
    logic [7:0] r_data,       w_data_nxt;
    logic       r_se0_seen,   w_se0_seen_nxt;
    logic       r_bc,         w_bc_nxt;
    logic       r_eop,        w_eop_nxt;
    logic       r_stuff,      w_stuff_nxt;
    logic       r_align,      w_align_nxt;
    logic       r_recv,       w_recv_nxt;

    logic       w_sample;
    logic       w_fall;
    logic [1:0] w_line;
    logic       w_bit;

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .run    (r_state != ST_IDLE),
        .d_plus (d_plus),
        .sample (w_sample),
        .fall   (w_fall)
    );

    assign w_line = {d_plus, d_minus};
    assign w_bit  = nrzi_bit(d_plus, r_prev_level);

    always_comb begin
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev_level;
        w_ones_nxt     = r_ones;
        w_bitcnt_nxt   = r_bitcnt;
        w_shift_nxt    = r_shift;
        w_data_nxt     = r_data;
        w_se0_seen_nxt = r_se0_seen;
        w_bc_nxt       = 1'b0;
        w_eop_nxt      = 1'b0;
        w_stuff_nxt    = 1'b0;
        w_align_nxt    = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && w_line == LINE_K) begin
                        w_state_nxt    = ST_RECEIVE;
                        w_prev_nxt     = 1'b1;
                        w_ones_nxt     = '0;
                        w_bitcnt_nxt   = '0;
                        w_se0_seen_nxt = 1'b0;
                    end
                end
                ST_RECEIVE: begin
                    if (w_sample) begin
                        // SE0 preempts any pending stuff-bit check
                        if (w_line == LINE_SE0) begin
                            w_state_nxt  = ST_EOP_WAIT;
                            w_align_nxt  = (r_bitcnt != 3'd0);
                            w_bitcnt_nxt = '0;
                        end else begin
                            w_prev_nxt = d_plus;
                            if (r_ones == STUFF_LIMIT) begin
                                w_ones_nxt = '0;
                                if (w_bit) begin
                                    w_stuff_nxt = 1'b1;
                                    w_state_nxt = ST_ERR_WAIT;
                                end
                            end else begin
                                w_ones_nxt   = w_bit ? r_ones + 3'd1 : 3'd0;
                                w_shift_nxt  = {w_bit, r_shift[7:1]};
                                w_bitcnt_nxt = r_bitcnt + 3'd1;
                                if (r_bitcnt == 3'd7) begin
                                    w_data_nxt = {w_bit, r_shift[7:1]};
                                    w_bc_nxt   = 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_EOP_WAIT: begin
                    if (w_sample && w_line == LINE_J) begin
                        w_eop_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ERR_WAIT: begin
                    if (w_sample) begin
                        if (w_line == LINE_SE0) begin
                            w_se0_seen_nxt = 1'b1;
                        end else if (w_line == LINE_J && r_se0_seen) begin
                            w_eop_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        w_recv_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_prev_level <= 1'b1;
            r_ones       <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_se0_seen   <= 1'b0;
            r_bc         <= 1'b0;
            r_eop        <= 1'b0;
            r_stuff      <= 1'b0;
            r_align      <= 1'b0;
            r_recv       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_level <= w_prev_nxt;
            r_ones       <= w_ones_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_shift      <= w_shift_nxt;
            r_data       <= w_data_nxt;
            r_se0_seen   <= w_se0_seen_nxt;
            r_bc         <= w_bc_nxt;
            r_eop        <= w_eop_nxt;
            r_stuff      <= w_stuff_nxt;
            r_align      <= w_align_nxt;
            r_recv       <= w_recv_nxt;
        end
    end

    assign Packet_Data   = r_data;
    assign byte_complete = r_bc;
    assign eop           = r_eop;
    assign stuff_error   = r_stuff;
    assign align_error   = r_align;
    assign receiving     = r_recv;

endmodule

// File: tb/tb_rx_byte_assembler.sv
// Bench for rx_byte_assembler: a USB line encoder (NRZI + bit stuffing) drives
// packets, decoded bytes and pulses are collected and checked per packet.
module tb_rx_byte_assembler;
    import usb_rx_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_plus;
    logic       d_minus;
    logic       enable;
    logic [7:0] Packet_Data;
    logic       byte_complete;
    logic       eop;
    logic       stuff_error;
    logic       align_error;
    logic       receiving;

    always #5 clk = ~clk;

    rx_byte_assembler #(.CLKS_PER_BIT(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .enable        (enable),
        .Packet_Data   (Packet_Data),
        .byte_complete (byte_complete),
        .eop           (eop),
        .stuff_error   (stuff_error),
        .align_error   (align_error),
        .receiving     (receiving)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] got_q[$];
    int n_eop   = 0;
    int n_stuff = 0;
    int n_align = 0;

    always @(negedge clk) begin
        if (byte_complete) got_q.push_back(Packet_Data);
        if (eop)           n_eop++;
        if (stuff_error)   n_stuff++;
        if (align_error)   n_align++;
    end

    int b_bytes, b_eop, b_stuff, b_align;

    task automatic snap();
        b_bytes = got_q.size();
        b_eop   = n_eop;
        b_stuff = n_stuff;
        b_align = n_align;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic int byte_at(input int idx);
        if (idx < got_q.size()) return int'(got_q[idx]);
        return -1;
    endfunction

    // Line encoder state: current level (1 = J) and consecutive-ones count
    logic tx_lvl;
    int   tx_ones;

    task automatic put(input logic dp, input logic dm, input int n);
        d_plus  = dp;
        d_minus = dm;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic raw(input bit b, input int n);
        if (!b) tx_lvl = ~tx_lvl;
        put(tx_lvl, ~tx_lvl, n);
    endtask

    task automatic dbit(input bit b, input int n, input bit brk);
        raw(b, n);
        if (b) tx_ones++; else tx_ones = 0;
        if (tx_ones == 6) begin
            raw(brk, n);
            tx_ones = 0;
        end
    endtask

    task automatic send_sync();
        logic [7:0] s;
        s       = SYNC_BYTE;
        tx_ones = 0;
        for (int i = 0; i < 8; i++) dbit(s[i], 8, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v, input int nbits, input bit drift, input bit brk);
        int len;
        for (int i = 0; i < nbits; i++) begin
            len = drift ? ((i % 3 == 2) ? 9 : 7) : 8;
            dbit(v[i], len, brk);
        end
    endtask

    task automatic send_eop();
        put(1'b0, 1'b0, 16);
        tx_lvl = 1'b1;
        put(1'b1, 1'b0, 8);
        put(1'b1, 1'b0, 16);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pd"},    Packet_Data,   0);
        check({tag, "_bc"},    byte_complete, 0);
        check({tag, "_eop"},   eop,           0);
        check({tag, "_stuff"}, stuff_error,   0);
        check({tag, "_align"}, align_error,   0);
        check({tag, "_recv"},  receiving,     0);
    endtask

    task automatic check_clean_packet(input string tag, input logic [7:0] exp_last);
        check({tag, "_nbytes"}, got_q.size() - b_bytes, 2);
        check({tag, "_sync"},   byte_at(b_bytes), int'(SYNC_BYTE));
        check({tag, "_data"},   byte_at(b_bytes + 1), int'(exp_last));
        check({tag, "_eop"},    n_eop - b_eop, 1);
        check({tag, "_errs"},   (n_stuff - b_stuff) + (n_align - b_align), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         drift;
        bit         brk;
        logic [7:0] exp_pd;
        int         exp_bytes;
        int         exp_stuff;
        int         exp_align;
    } vec_t;

    vec_t tab[6];

    initial begin
        tab[0] = '{8'hA5, 8, 1'b0, 1'b0, 8'hA5, 2, 0, 0};
        tab[1] = '{8'hFF, 8, 1'b0, 1'b0, 8'hFF, 2, 0, 0};
        tab[2] = '{8'h3C, 8, 1'b1, 1'b0, 8'h3C, 2, 0, 0};
        tab[3] = '{8'h15, 5, 1'b0, 1'b0, 8'h80, 1, 0, 1};
        tab[4] = '{8'hFF, 8, 1'b0, 1'b1, 8'h80, 1, 1, 0};
        tab[5] = '{8'h00, 8, 1'b0, 1'b0, 8'h00, 2, 0, 0};

        n_rst   = 1'b0;
        enable  = 1'b1;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        tx_lvl  = 1'b1;
        tx_ones = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        n_rst = 1'b1;
        put(1'b1, 1'b0, 16);

        for (int i = 0; i < 6; i++) begin
            snap();
            send_sync();
            send_byte(tab[i].data, tab[i].nbits, tab[i].drift, tab[i].brk);
            send_eop();
            check($sformatf("row%0d_nbytes", i), got_q.size() - b_bytes, tab[i].exp_bytes);
            check($sformatf("row%0d_sync", i),   byte_at(b_bytes), int'(SYNC_BYTE));
            check($sformatf("row%0d_pd", i),     Packet_Data, tab[i].exp_pd);
            check($sformatf("row%0d_eop", i),    n_eop - b_eop, 1);
            check($sformatf("row%0d_stuff", i),  n_stuff - b_stuff, tab[i].exp_stuff);
            check($sformatf("row%0d_align", i),  n_align - b_align, tab[i].exp_align);
            check($sformatf("row%0d_recv", i),   receiving, 0);
        end

        // Enable dropped partway through the data byte
        snap();
        send_sync();
        send_byte(8'h6E, 4, 1'b0, 1'b0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("endrop_recv", receiving, 0);
        send_byte(8'h06, 4, 1'b0, 1'b0);
        send_eop();
        check("endrop_nbytes", got_q.size() - b_bytes, 1);
        check("endrop_pd",     Packet_Data, 8'h80);
        check("endrop_eop",    n_eop - b_eop, 0);
        enable = 1'b1;
        put(1'b1, 1'b0, 16);
        snap();
        send_sync();
        send_byte(8'h5A, 8, 1'b0, 1'b0);
        send_eop();
        check_clean_packet("reen", 8'h5A);

        // Asynchronous reset after 12 bit times
        snap();
        send_sync();
        send_byte(8'h99, 4, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tx_lvl = 1'b1;
        put(1'b1, 1'b0, 4);
        n_rst = 1'b1;
        put(1'b1, 1'b0, 16);
        check("midrst_nopulse", (n_eop - b_eop) + (n_stuff - b_stuff) + (n_align - b_align), 0);
        snap();
        send_sync();
        send_byte(8'hC3, 8, 1'b0, 1'b0);
        send_eop();
        check_clean_packet("postrst", 8'hC3);

        // Random multi-byte packets against the encoder-side expected byte list
        for (int p = 0; p < 25; p++) begin
            logic [7:0] exp_q[$];
            int nb;
            nb = $urandom_range(1, 3);
            exp_q = {};
            exp_q.push_back(SYNC_BYTE);
            snap();
            send_sync();
            for (int k = 0; k < nb; k++) begin
                logic [7:0] v;
                v = 8'($urandom);
                exp_q.push_back(v);
                send_byte(v, 8, 1'b0, 1'b0);
            end
            send_eop();
            check($sformatf("rnd%0d_nbytes", p), got_q.size() - b_bytes, exp_q.size());
            for (int k = 0; k < exp_q.size(); k++)
                check($sformatf("rnd%0d_b%0d", p, k), byte_at(b_bytes + k), int'(exp_q[k]));
            check($sformatf("rnd%0d_eop", p),  n_eop - b_eop, 1);
            check($sformatf("rnd%0d_errs", p), (n_stuff - b_stuff) + (n_align - b_align), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
